// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin arbiter sharing one add/sub/mul/and ALU, one op in flight
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_mode,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic [ID_W-1:0] rr_ptr, grant, id_q;
    logic found;
    logic [1:0] mode_q;
    logic [WIDTH-1:0] a_q, b_q, alu;
    // Descending scan so the closest requester at or after rr_ptr wins
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found) req_ready[grant] = 1'b1;
    end
    always_comb alu = mode_q == 2'b00 ? a_q + b_q :
                      mode_q == 2'b01 ? a_q - b_q :
                      mode_q == 2'b10 ? a_q * b_q : a_q & b_q;
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            rsp_valid <= 1'b0;
            rsp_result <= '0;
            rsp_id <= '0;
            id_q <= '0;
            mode_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    mode_q <= req_mode[int'(grant)*2 +: 2];
                    a_q <= req_a[int'(grant)*WIDTH +: WIDTH];
                    b_q <= req_b[int'(grant)*WIDTH +: WIDTH];
                    id_q <= grant;
                    rr_ptr <= grant == ID_W'(NUM_REQ - 1) ? '0 : grant + 1'b1;
                    state <= EXEC;
                end
                EXEC: begin
                    rsp_result <= alu;
                    rsp_id <= id_q;
                    rsp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: directed stimulus with a response scoreboard for alu_rr_scheduler
module tb_alu_rr_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] req_valid, req_ready;
    logic [7:0] req_mode;
    logic [15:0] req_a, req_b;
    logic rsp_valid, rsp_ready, busy;
    logic [3:0] rsp_result;
    logic [1:0] rsp_id;
    int tests = 0;
    int fails = 0;
    logic [5:0] sb[$];
    logic [5:0] exp_rsp;
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] t3_res[4] = '{4'h0, 4'hF, 4'h9, 4'h6};

    alu_rr_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(int i, logic [1:0] m, logic [3:0] a, logic [3:0] b);
        req_mode[i*2 +: 2] = m;
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 8'(busy), 8'd0);
    endtask

    task automatic issue(logic [3:0] mask, int g, logic [3:0] r, string name);
        req_valid = mask;
        #1;
        check(name, 8'(req_ready), 8'(4'b1 << g));
        sb.push_back({2'(g), r});
        tick();
        req_valid = '0;
        wait_idle(name);
    endtask

    // Every accepted response is matched against the oldest expected one
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got id %0d result %0h expected none", rsp_id, rsp_result);
            end else begin
                exp_rsp = sb.pop_front();
                check("rsp_id", 8'(rsp_id), 8'(exp_rsp[5:4]));
                check("rsp_result", 8'(rsp_result), 8'(exp_rsp[3:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_mode = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        #1;
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        check("rst_rsp_result", 8'(rsp_result), 8'd0);
        check("rst_rsp_id", 8'(rsp_id), 8'd0);
        check("rst_req_ready", 8'(req_ready), 8'd0);
        // Single request latency
        set_payload(0, 2'b00, 4'h3, 4'h4);
        req_valid = 4'b0001;
        #1;
        check("t1_grant", 8'(req_ready), 8'h01);
        sb.push_back({2'd0, 4'h7});
        tick();
        req_valid = '0;
        check("t1_cycle1_valid", 8'(rsp_valid), 8'd0);
        check("t1_cycle1_ready", 8'(req_ready), 8'd0);
        tick();
        check("t1_cycle2_valid", 8'(rsp_valid), 8'd1);
        wait_idle("t1");
        // Wrapping arithmetic
        set_payload(1, 2'b01, 4'h2, 4'h5);
        issue(4'b0010, 1, 4'hD, "t2_sub");
        set_payload(2, 2'b10, 4'h5, 4'h7);
        issue(4'b0100, 2, 4'h3, "t2_mul");
        set_payload(3, 2'b11, 4'hC, 4'hA);
        issue(4'b1000, 3, 4'h8, "t2_and");
        // All requesters continuously valid
        set_payload(0, 2'b00, 4'hF, 4'h1);
        set_payload(1, 2'b01, 4'h0, 4'h1);
        set_payload(2, 2'b10, 4'h3, 4'h3);
        set_payload(3, 2'b11, 4'hF, 4'h6);
        req_valid = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            #1;
            check($sformatf("t3_ready_c%0d", c), 8'(req_ready),
                  (c % 3 == 0) ? 8'(4'b1 << order[c/3]) : 8'd0);
            if (c % 3 == 0) sb.push_back({2'(order[c/3]), t3_res[order[c/3]]});
            tick();
        end
        req_valid = '0;
        wait_idle("t3");
        // Response back-pressure
        rsp_ready = 1'b0;
        set_payload(1, 2'b00, 4'h5, 4'h6);
        set_payload(2, 2'b10, 4'h4, 4'h4);
        req_valid = 4'b0010;
        #1;
        check("t4_grant", 8'(req_ready), 8'h02);
        sb.push_back({2'd1, 4'hB});
        tick();
        req_valid = 4'b0100;
        #1;
        check("t4_exec_ready", 8'(req_ready), 8'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t4_hold_valid", 8'(rsp_valid), 8'd1);
            check("t4_hold_result", 8'(rsp_result), 8'hB);
            check("t4_hold_id", 8'(rsp_id), 8'd1);
            check("t4_hold_busy", 8'(busy), 8'd1);
            check("t4_hold_ready", 8'(req_ready), 8'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("t4_idle_busy", 8'(busy), 8'd0);
        check("t4_idle_ready", 8'(req_ready), 8'h04);
        req_valid = '0;
        // Pointer wrap
        set_payload(3, 2'b11, 4'hF, 4'h9);
        issue(4'b1000, 3, 4'h9, "t5_r3");
        set_payload(2, 2'b01, 4'h2, 4'h5);
        issue(4'b0100, 2, 4'hD, "t5_r2_wrap");
        set_payload(0, 2'b00, 4'h1, 4'h2);
        issue(4'b1001, 3, 4'h9, "t5_ptr3");
        // Reset during EXEC drops the op
        set_payload(1, 2'b00, 4'h7, 4'h7);
        req_valid = 4'b0010;
        #1;
        check("t6_grant", 8'(req_ready), 8'h02);
        tick();
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", 8'(rsp_valid), 8'd0);
        check("t6_rst_busy", 8'(busy), 8'd0);
        req_valid = '0;
        #1;
        check("t6_rst_ready", 8'(req_ready), 8'd0);
        tick();
        check("t6_rst_valid2", 8'(rsp_valid), 8'd0);
        rst_n = 1'b1;
        issue(4'b0011, 0, 4'h3, "t6_r0_first");
        issue(4'b0010, 1, 4'hE, "t6_r1_next");
        repeat (2) tick();
        check("sb_empty", 8'(sb.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
